apb_multi_slave_master: RTL
===========================

# apb_multi_slave_master

Parametrised APB master bridge replacing the fixed two-slave (GPIO/UART) front end of the peripheral subsystem. It accepts single read/write commands over a valid/ready interface and decodes the target slave from address bits. It runs an APB3/APB4 transfer with PREADY wait states, PSLVERR and a watchdog timeout, and returns one response per command. It sits between the system-side command source and any number of APB slaves (GPIO, UART, future timers).

## Interface
- DATA_WIDTH, 32: PWDATA/PRDATA width; multiple of 8.
- ADDRESS_WIDTH, 32: address width.
- STRB_WIDTH, DATA_WIDTH/8: byte-strobe width.
- SLAVES_NUM, 4: number of slaves, 1..16.
- SEL_LSB, 12: lowest address bit of the slave-index field.
- SEL_BITS, 4: width of the slave-index field; 2^SEL_BITS >= SLAVES_NUM.
- TIMEOUT_CYCLES, 255: number of ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  sole clock; all logic on rising edge.
- PRESETn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDRESS_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  STRB_WIDTH  write byte strobes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  PSLVERR, decode error or timeout.
- rsp_timeout  out  1  the transfer was aborted by the timeout.
- PADDR  out  ADDRESS_WIDTH  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  STRB_WIDTH  APB strobes; 0 on reads.
- PSEL  out  SLAVES_NUM  one-hot slave select.
- PENABLE  out  1  APB access phase.
- PRDATA  in  SLAVES_NUM*DATA_WIDTH  concatenated slave read data; slave i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- PREADY  in  SLAVES_NUM  per-slave ready.
- PSLVERR  in  SLAVES_NUM  per-slave error.

## Operation
- FSM states and transitions:
  - IDLE: cmd_ready=1. On cmd_valid, capture the command and the index idx = cmd_addr[SEL_LSB +: SEL_BITS].
    - If idx < SLAVES_NUM, go to SETUP.
    - Otherwise go to RESP with err=1. No PSEL is asserted.
  - SETUP: PSEL[idx]=1, PENABLE=0. Always goes to ACCESS.
  - ACCESS: PSEL[idx]=1, PENABLE=1. Sample PREADY[idx].
    - If PREADY[idx]=1, capture PRDATA[idx] (reads only) and PSLVERR[idx], then go to RESP.
    - Otherwise increment the wait counter. When the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), go to RESP with err=1, timeout=1.
  - RESP: rsp_valid=1, PSEL=0, PENABLE=0, cmd_ready=0. Always goes to IDLE.
- PADDR, PWRITE, PWDATA and PSTRB are registered at accept and are stable from SETUP through the end of ACCESS. They hold their last value in IDLE.
- PSTRB = cmd_strb on writes and 0 on reads.
- rsp_rdata = captured PRDATA on a successful read. It is 0 on writes and on any error.
- rsp_err, rsp_rdata and rsp_timeout are valid only while rsp_valid=1. They are 0 otherwise.
- Wait counter: width $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. It clears on entry to SETUP and never wraps.
- PREADY, PSLVERR and PRDATA of unselected slaves are ignored.
- cmd_valid is ignored outside IDLE. The command source must hold the command until it sees cmd_ready.

## Timing
- Reset: while PRESETn is low at a rising edge, the next state is IDLE and all registered outputs are 0 (PADDR, PWRITE, PWDATA, PSTRB, PSEL, PENABLE, rsp_*). cmd_ready is 1 (IDLE) but commands are ignored while PRESETn=0.
- Reset mid-transfer: abort immediately. PSEL and PENABLE are 0 after the edge and no rsp_valid is generated for the aborted command.
- Command accepted at edge k: SETUP in cycle k+1, ACCESS from k+2.
- Zero-wait transfer: rsp_valid in cycle k+3 and cmd_ready high again in k+4. This gives a 4-cycle back-to-back throughput.
- Each PREADY-low ACCESS cycle adds 1 cycle of latency.
- Decode error: rsp_valid in cycle k+1. No APB activity.
- Timeout: after TIMEOUT_CYCLES ACCESS cycles with PREADY low, PSEL and PENABLE drop and rsp_valid follows in the next cycle.
- If PREADY rises in the same cycle the counter hits its limit, PREADY wins: normal completion, timeout=0.

## Test plan
- Write to slave 1: addr=0x1010, wdata=0xA5A5_0096, strb=4'hF, PREADY tied 1.
  - Required: PSEL=4'b0010 for 2 cycles, PENABLE in the 2nd cycle, PWRITE=1.
  - Required: rsp_valid at k+3 with err=0, rdata=0.
- Read from slave 2 with 3 wait states, PRDATA[2]=0x1234_5678.
  - Required: ACCESS lasts 4 cycles, PSTRB=0.
  - Required: rsp_rdata=0x1234_5678, rsp_valid at k+6.
- PSLVERR: slave 0 read completes with PSLVERR=1 and PRDATA=0xFFFF_FFFF.
  - Required: rsp_err=1, rsp_rdata=0, rsp_timeout=0.
- Decode error: SLAVES_NUM=4, addr=0x5000.
  - Required: PSEL stays 0, rsp_valid at k+1 with err=1.
- Timeout: TIMEOUT_CYCLES=8, PREADY held 0.
  - Required: 8 ACCESS cycles, then rsp_err=1, rsp_timeout=1.
  - Also: PREADY rising in the 8th cycle must produce a normal completion.
- Reset mid-ACCESS: PRESETn low for 1 cycle during a wait-stated read.
  - Required: PSEL and PENABLE are 0 next cycle, no rsp_valid.
  - Required: the next command completes normally.

Source files
------------

// File: rtl/apb_multi_slave_master.sv
`default_nettype none
// ============================================================================
//  Module   : apb_multi_slave_master
//  Purpose  : Parametrised APB3/APB4 master bridge. It accepts single
//             read/write commands over a valid/ready interface and decodes
//             the target slave from an address bit field. It runs one APB
//             transfer per command, honouring PREADY wait states, PSLVERR
//             and a watchdog timeout, and returns a one-cycle response
//             pulse for every command.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    PCLK        in   clock, rising edge
//    PRESETn     in   synchronous active-low reset
//    cmd_valid   in   command request
//    cmd_ready   out  bridge can accept a command (IDLE)
//    cmd_write   in   1 = write, 0 = read
//    cmd_addr    in   byte address (slave index in [SEL_LSB +: SEL_BITS])
//    cmd_wdata   in   write data
//    cmd_strb    in   write byte strobes
//    rsp_valid   out  one-cycle response pulse
//    rsp_rdata   out  read data (0 on writes and errors)
//    rsp_err     out  PSLVERR, decode error or timeout
//    rsp_timeout out  transfer aborted by the watchdog
//    PADDR/PWRITE/PWDATA/PSTRB/PSEL/PENABLE   out  APB request
//    PRDATA/PREADY/PSLVERR                    in   APB per-slave responses
// ============================================================================
module apb_multi_slave_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int SLAVES_NUM     = 4,
  parameter int SEL_LSB        = 12,
  parameter int SEL_BITS       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [STRB_WIDTH-1:0]            cmd_strb,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  output logic [ADDRESS_WIDTH-1:0]         PADDR,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [STRB_WIDTH-1:0]            PSTRB,
  output logic [SLAVES_NUM-1:0]            PSEL,
  output logic                             PENABLE,
  input  logic [SLAVES_NUM*DATA_WIDTH-1:0] PRDATA,
  input  logic [SLAVES_NUM-1:0]            PREADY,
  input  logic [SLAVES_NUM-1:0]            PSLVERR
);

  localparam int c_CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit c_TO_EN = (TIMEOUT_CYCLES != 0);
  // Counter value seen during the last permitted PREADY-low ACCESS cycle.
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_TO_EN ? c_CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [SEL_BITS:0]   c_SLAVES   = (SEL_BITS + 1)'(SLAVES_NUM);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SEL_BITS-1:0]     r_idx;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;
  logic                    r_timeout;

  logic [SEL_BITS-1:0]     w_cmd_idx;
  logic                    w_decode_ok;
  logic                    w_sel_ready;
  logic                    w_sel_err;
  logic [DATA_WIDTH-1:0]   w_sel_rdata;
  logic                    w_timeout_hit;

  assign w_cmd_idx     = cmd_addr[SEL_LSB +: SEL_BITS];
  assign w_decode_ok   = ({1'b0, w_cmd_idx} < c_SLAVES);
  assign w_timeout_hit = c_TO_EN && (r_cnt == c_CNT_LAST);

  // Only the addressed slave's response lines are looked at.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < SLAVES_NUM; i++) begin
      if (r_idx == SEL_BITS'(i)) begin
        w_sel_ready = PREADY[i];
        w_sel_err   = PSLVERR[i];
        w_sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State register
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    PENABLE     = 1'b0;
    PSEL        = '0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_state_nxt = w_decode_ok ? ST_SETUP : ST_RESP;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        PENABLE = 1'b1;
        // PREADY takes priority over an expiring watchdog.
        if (w_sel_ready || w_timeout_hit) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if ((r_state == ST_SETUP) || (r_state == ST_ACCESS)) begin
      for (int i = 0; i < SLAVES_NUM; i++) begin
        PSEL[i] = (r_idx == SEL_BITS'(i));
      end
    end
  end

  // Request capture, wait counter and response capture
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            PADDR     <= cmd_addr;
            PWRITE    <= cmd_write;
            PWDATA    <= cmd_wdata;
            PSTRB     <= cmd_write ? cmd_strb : '0;
            r_idx     <= w_cmd_idx;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_err     <= ~w_decode_ok;
            r_timeout <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (w_sel_ready) begin
            r_err   <= w_sel_err;
            r_rdata <= (PWRITE || w_sel_err) ? '0 : w_sel_rdata;
          end else if (w_timeout_hit) begin
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
          end else if (c_TO_EN) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Response fields read as zero outside the response pulse.
  assign rsp_rdata   = rsp_valid ? r_rdata : '0;
  assign rsp_err     = rsp_valid & r_err;
  assign rsp_timeout = rsp_valid & r_timeout;

endmodule
`default_nettype wire
